// File: rtl/memory_stage_pkg.sv
// Shared types for the memory stage: access sizes, FSM states and the decoded
// instruction fields consumed downstream of execute.
package pkg_opengpu;

    localparam int XLEN   = 32;
    localparam int ADDR_W = 32;

    typedef enum logic [1:0] {
        MEM_B = 2'd0,
        MEM_H = 2'd1,
        MEM_W = 2'd2
    } mem_size_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        WAIT  = 2'd2,
        DRAIN = 2'd3
    } mem_state_t;

    typedef struct packed {
        logic [4:0] rd;
        logic       reg_write;
        logic       mem_read;
        logic       mem_write;
        mem_size_t  mem_size;
        logic       mem_unsigned;
    } decoded_instr_t;

    function automatic logic is_misaligned(input mem_size_t size, input logic [1:0] off);
        logic mis;
        mis = 1'b0;
        case (size)
            MEM_H:   mis = off[0];
            MEM_W:   mis = (off != 2'b00);
            default: mis = 1'b0;
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/memory_stage_if.sv
// Data-memory request/response port: one response per accepted request,
// arriving at least one cycle after acceptance.
interface memory_stage_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic                  req_valid;
    logic                  req_ready;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic                  req_we;
    logic [DATA_WIDTH-1:0] req_wdata;
    logic [3:0]            req_wstrb;
    logic                  resp_valid;
    logic [DATA_WIDTH-1:0] resp_rdata;

    modport master (
        output req_valid, req_addr, req_we, req_wdata, req_wstrb,
        input  req_ready, resp_valid, resp_rdata
    );

    modport slave (
        input  req_valid, req_addr, req_we, req_wdata, req_wstrb,
        output req_ready, resp_valid, resp_rdata
    );
endinterface

// File: rtl/memory_stage_lsu_align.sv
// Combinational lane steering: store data replication and byte strobes, plus
// load byte/half extraction with sign or zero extension.
module lsu_align
    import pkg_opengpu::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  mem_size_t             st_size,
    input  logic [1:0]            st_off,
    input  logic [DATA_WIDTH-1:0] st_data,
    output logic [DATA_WIDTH-1:0] st_wdata,
    output logic [3:0]            st_wstrb,
    input  mem_size_t             ld_size,
    input  logic [1:0]            ld_off,
    input  logic                  ld_unsigned,
    input  logic [DATA_WIDTH-1:0] ld_rdata,
    output logic [DATA_WIDTH-1:0] ld_data
);

    function automatic logic [DATA_WIDTH-1:0] ext_byte(input logic signed [7:0] b, input logic uns);
        logic signed [DATA_WIDTH-1:0] sx;
        sx = DATA_WIDTH'(b);
        return uns ? {{(DATA_WIDTH-8){1'b0}}, b} : sx;
    endfunction

    function automatic logic [DATA_WIDTH-1:0] ext_half(input logic signed [15:0] h, input logic uns);
        logic signed [DATA_WIDTH-1:0] sx;
        sx = DATA_WIDTH'(h);
        return uns ? {{(DATA_WIDTH-16){1'b0}}, h} : sx;
    endfunction

    logic [DATA_WIDTH-1:0] shifted;

    always_comb begin
        st_wdata = st_data;
        st_wstrb = 4'b1111;
        case (st_size)
            MEM_B: begin
                st_wdata = {4{st_data[7:0]}};
                st_wstrb = 4'b0001 << st_off;
            end
            MEM_H: begin
                st_wdata = {2{st_data[15:0]}};
                st_wstrb = 4'b0011 << st_off;
            end
            default: ;
        endcase
    end

    // The addressed byte/half is moved down to bit 0 before extension.
    always_comb begin
        shifted = ld_rdata >> {ld_off, 3'b000};
        case (ld_size)
            MEM_B:   ld_data = ext_byte(shifted[7:0], ld_unsigned);
            MEM_H:   ld_data = ext_half(shifted[15:0], ld_unsigned);
            default: ld_data = ld_rdata;
        endcase
    end

endmodule

// File: rtl/memory_stage.sv
// Memory pipeline stage: passes ALU results through in one cycle and runs
// loads/stores over the valid/ready data port, stalling upstream meanwhile.
module memory_stage
    import pkg_opengpu::*;
#(
    parameter int ADDR_WIDTH = ADDR_W,
    parameter int DATA_WIDTH = XLEN
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  decoded_instr_t         decoded,
    input  logic [DATA_WIDTH-1:0]  alu_in,
    input  logic [DATA_WIDTH-1:0]  wdata_in,
    input  logic [ADDR_WIDTH-1:0]  pc_in,
    input  logic                   valid_in,
    input  logic                   flush,
    memory_stage_if.master         dmem,
    output logic                   mem_stall,
    output logic [DATA_WIDTH-1:0]  wb_data,
    output logic [4:0]             wb_rd,
    output logic                   wb_reg_write,
    output logic [ADDR_WIDTH-1:0]  pc_out,
    output logic                   valid_out,
    output logic                   misaligned_exc
);

    mem_state_t state, next_state;

    logic mem_op, misaligned, issue;

    logic [ADDR_WIDTH-1:0] req_addr_p0;
    mem_size_t             req_size_p0;
    logic                  req_unsigned_p0;
    logic                  req_load_p0;
    logic                  req_we_p0;
    logic [4:0]            req_rd_p0;
    logic [ADDR_WIDTH-1:0] req_pc_p0;
    logic [DATA_WIDTH-1:0] req_wdata_p0;
    logic [3:0]            req_wstrb_p0;

    logic [DATA_WIDTH-1:0] st_wdata;
    logic [3:0]            st_wstrb;
    logic [DATA_WIDTH-1:0] ld_data;

    assign mem_op     = valid_in && (decoded.mem_read || decoded.mem_write);
    assign misaligned = mem_op && is_misaligned(decoded.mem_size, alu_in[1:0]);
    assign issue      = mem_op && !misaligned && !flush;

    // Store lanes are formatted from the incoming operands; loads are extracted
    // using the latched request so the response can arrive much later.
    lsu_align #(.DATA_WIDTH(DATA_WIDTH)) u_align (
        .st_size     (decoded.mem_size),
        .st_off      (alu_in[1:0]),
        .st_data     (wdata_in),
        .st_wdata    (st_wdata),
        .st_wstrb    (st_wstrb),
        .ld_size     (req_size_p0),
        .ld_off      (req_addr_p0[1:0]),
        .ld_unsigned (req_unsigned_p0),
        .ld_rdata    (dmem.resp_rdata),
        .ld_data     (ld_data)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= next_state;
    end

    // A response coinciding with a flush in WAIT is consumed here rather than
    // drained, otherwise DRAIN would wait for a response that never comes.
    always_comb begin
        next_state = state;
        mem_stall  = 1'b0;
        case (state)
            IDLE: begin
                if (issue) begin
                    next_state = REQ;
                    mem_stall  = 1'b1;
                end
            end
            REQ: begin
                mem_stall = 1'b1;
                if (dmem.req_ready) next_state = flush ? DRAIN : WAIT;
                else if (flush)     next_state = IDLE;
            end
            WAIT: begin
                if (dmem.resp_valid) next_state = IDLE;
                else begin
                    mem_stall = 1'b1;
                    if (flush) next_state = DRAIN;
                end
            end
            DRAIN: begin
                if (dmem.resp_valid) next_state = IDLE;
                else                 mem_stall = 1'b1;
            end
            default: next_state = IDLE;
        endcase
    end

    // ---- stage p0: request register ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req_addr_p0     <= '0;
            req_size_p0     <= MEM_B;
            req_unsigned_p0 <= 1'b0;
            req_load_p0     <= 1'b0;
            req_we_p0       <= 1'b0;
            req_rd_p0       <= '0;
            req_pc_p0       <= '0;
            req_wdata_p0    <= '0;
            req_wstrb_p0    <= '0;
        end else if (state == IDLE && issue) begin
            req_addr_p0     <= ADDR_WIDTH'(alu_in);
            req_size_p0     <= decoded.mem_size;
            req_unsigned_p0 <= decoded.mem_unsigned;
            req_load_p0     <= decoded.mem_read && !decoded.mem_write;
            req_we_p0       <= decoded.mem_write;
            req_rd_p0       <= decoded.rd;
            req_pc_p0       <= pc_in;
            req_wdata_p0    <= st_wdata;
            req_wstrb_p0    <= decoded.mem_write ? st_wstrb : 4'b0000;
        end
    end

    assign dmem.req_valid = (state == REQ);
    assign dmem.req_addr  = {req_addr_p0[ADDR_WIDTH-1:2], 2'b00};
    assign dmem.req_we    = req_we_p0;
    assign dmem.req_wdata = req_wdata_p0;
    assign dmem.req_wstrb = req_wstrb_p0;

    // ---- stage p1: writeback registers ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wb_data        <= '0;
            wb_rd          <= '0;
            wb_reg_write   <= 1'b0;
            pc_out         <= '0;
            valid_out      <= 1'b0;
            misaligned_exc <= 1'b0;
        end else begin
            valid_out      <= 1'b0;
            misaligned_exc <= 1'b0;
            wb_reg_write   <= 1'b0;
            case (state)
                IDLE: begin
                    if (valid_in && !flush) begin
                        if (misaligned) begin
                            misaligned_exc <= 1'b1;
                        end else if (!mem_op) begin
                            wb_data      <= alu_in;
                            wb_rd        <= decoded.rd;
                            wb_reg_write <= decoded.reg_write;
                            pc_out       <= pc_in;
                            valid_out    <= 1'b1;
                        end
                    end
                end
                WAIT: begin
                    if (dmem.resp_valid && !flush) begin
                        wb_data      <= req_load_p0 ? ld_data : '0;
                        wb_rd        <= req_rd_p0;
                        wb_reg_write <= req_load_p0;
                        pc_out       <= req_pc_p0;
                        valid_out    <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
